memory: RTL and testbench
=========================

Name: memory

Overview:
- Pipeline stage directly downstream of execute. Consumes the execute_data_t bundle, performs loads/stores over the data bus (dbus request/response handshake) and registers the result into memory_data_t for writeback.
- Generates the byte strobe and lane shift for stores, and the lane select plus sign/zero extension for loads.
- Stalls the pipe while a bus transaction is outstanding.
- Exports M-stage forwarding fields.

Parameters:
- XLEN, 64, datapath width; must equal the width of word_t.
- MISALIGN_CHECK, 1, when 1 misaligned accesses are suppressed and flagged; when 0 they are issued unchecked.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dataE  in  execute_data_t  pc, ctl (regwrite, memread, memwrite, msize, mem_unsigned), result_alu (address for memory ops), wd (store data), wa
- validE  in  1  dataE holds a real instruction
- dreq  out  dbus_req_t  valid, addr[63:0], size (msize_t), strobe[7:0], data[63:0]
- dresp  in  dbus_resp_t  addr_ok, data_ok, data[63:0]
- stallM  out  1  freeze upstream stages this cycle
- dataM  out  memory_data_t  pc, ctl, result (ALU or load value), wa, misalign
- validM  out  1  dataM holds a real instruction
- forward  out  forward_data_t  waM, resultM, regwriteM; driven from dataM/validM

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE.
  - validM=0; dataM all zero; dreq.valid=0.
  - forward.regwriteM=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - memop = validE & (ctl.memread | ctl.memwrite) & ~misalign.
  - If memop: dreq.valid=1 combinationally in the same cycle.
    - If dresp.data_ok is also 1 that cycle: complete immediately, stallM=0.
    - Otherwise go to BUSY with stallM=1.
  - If not memop: stallM=0; no bus request.
- BUSY:
  - dreq.valid=1; addr/size/strobe/data are held constant from the IDLE cycle (dataE is frozen by stallM).
  - stallM=1 until the cycle dresp.data_ok=1.
  - That cycle: stallM=0, state goes to IDLE.
  - addr_ok is ignored; completion is defined by data_ok only.
- Output register:
  - Updates on every clk edge where stallM=0.
  - validM <= validE; dataM <= formatted bundle.
  - While stallM=1, validM <= 0 (bubble inserted) and dataM fields are don't-care except ctl.regwrite=0.
- Latency: non-memory ops take 1 cycle (dataE to dataM). Memory ops take 1 cycle plus the wait cycles until data_ok.
- Store formatting (off = addr[2:0]):
  - dreq.data = wd << (8*off).
  - strobe = base << off, where base is 0x01/0x03/0x0F/0xFF for B/H/W/D.
  - Loads drive strobe=0.
- Load formatting:
  - raw = dresp.data >> (8*off).
  - Truncate to 8/16/32/64 bits.
  - Sign-extend, or zero-extend when mem_unsigned=1.
  - This value becomes dataM.result. Non-loads pass result_alu.
- Misalign (when MISALIGN_CHECK=1):
  - H with off[0]!=0; W with off[1:0]!=0; D with off!=0.
  - Effect: no bus request, dataM.misalign=1, dataM.ctl.regwrite=0, completes in 1 cycle.
- Address: dreq.addr = result_alu unmodified; the low bits are also conveyed by strobe/size.
- Reset mid-transaction: the FSM returns to IDLE and dreq.valid drops in the next cycle. The bus slave must tolerate an abandoned request.
- validE=0 with memread/memwrite=1: no request is issued.
- Forwarding:
  - forward.regwriteM = validM & dataM.ctl.regwrite.
  - forward.waM = dataM.wa; forward.resultM = dataM.result.

Decomposition:
- pipes package:
  - memory_data_t typedef.
  - forward_data_t extended with waM/resultM/regwriteM.
  - mem_state_t enum {IDLE, BUSY}.
- common package: dbus_req_t, dbus_resp_t, msize_t (MSIZE1/2/4/8), strobe base constants.
- Sub-module mem_format (combinational):
  - Store shift and strobe.
  - Load extract and extend.
  - Misalign detect.
  - The stage keeps the FSM and the output register.

Test Plan:
- ALU op, validE=1, result_alu=0x1234, regwrite=1 -> next cycle validM=1, dataM.result=0x1234, forward.regwriteM=1, dreq.valid never 1.
- SB addr=0x80000003, wd=0xAB, data_ok after 2 wait cycles:
  - dreq.strobe=0x08, dreq.data[31:24]=0xAB.
  - stallM=1 for 2 cycles, then validM=1 one cycle later.
- LB addr=0x1005, dresp.data=0x0000_80FF_0000_0000, data_ok same cycle:
  - stallM=0; dataM.result=0xFFFF_FFFF_FFFF_FF80.
  - Same access with LBU -> 0x80.
- LW addr=0x1004, dresp.data=0x8765_4321_xxxx_xxxx -> result=0xFFFF_FFFF_8765_4321; LWU -> 0x8765_4321.
- SD addr=0x1004 -> dreq.valid stays 0, dataM.misalign=1, regwrite=0, no stall.
- Assert reset while in BUSY -> next cycle dreq.valid=0, validM=0, stallM=0, state IDLE; a following LD completes normally.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types for the memory stage: pipeline bundles, data-bus request/response and the stage FSM states.
package memory_pkg;

    typedef logic [63:0] word_t;
    typedef logic [63:0] addr_t;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

    localparam strobe_t STROBE_B = 8'h01;
    localparam strobe_t STROBE_H = 8'h03;
    localparam strobe_t STROBE_W = 8'h0F;
    localparam strobe_t STROBE_D = 8'hFF;

    function automatic strobe_t strobeBase(input msize_t size);
        unique case (size)
            MSIZE1:  return STROBE_B;
            MSIZE2:  return STROBE_H;
            MSIZE4:  return STROBE_W;
            default: return STROBE_D;
        endcase
    endfunction

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        msize_t msize;
        logic   mem_unsigned;
    } control_t;

    typedef struct packed {
        addr_t      pc;
        control_t   ctl;
        word_t      result_alu;
        word_t      wd;
        creg_addr_t wa;
    } execute_data_t;

    typedef struct packed {
        addr_t      pc;
        control_t   ctl;
        word_t      result;
        creg_addr_t wa;
        logic       misalign;
    } memory_data_t;

    typedef struct packed {
        creg_addr_t waM;
        word_t      resultM;
        logic       regwriteM;
    } forward_data_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef enum logic {IDLE, BUSY} mem_state_t;

endpackage

// File: rtl/memory_format.sv
// Combinational lane logic: store shift/strobe, load extract/extend and misalignment detection.
module memory_format
    import memory_pkg::*;
#(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic [2:0] offset,
    input  msize_t     msize,
    input  logic       memread,
    input  logic       memwrite,
    input  logic       memUnsigned,
    input  word_t      storeData,
    input  word_t      readData,
    output strobe_t    strobe,
    output word_t      busData,
    output word_t      loadValue,
    output logic       misalign
);

    logic [5:0] shamt;
    logic       misalignRaw;
    word_t      raw;

    assign shamt = {offset, 3'b000};

    always_comb begin
        misalignRaw = 1'b0;
        unique case (msize)
            MSIZE1:  misalignRaw = 1'b0;
            MSIZE2:  misalignRaw = offset[0];
            MSIZE4:  misalignRaw = |offset[1:0];
            default: misalignRaw = |offset;
        endcase
    end

    assign misalign = MISALIGN_CHECK && (memread || memwrite) && misalignRaw;

    // Loads never drive byte enables; the slave returns the whole aligned doubleword.
    assign strobe  = memwrite ? strobe_t'(strobeBase(msize) << offset) : '0;
    assign busData = storeData << shamt;
    assign raw     = readData >> shamt;

    always_comb begin
        loadValue = raw;
        unique case (msize)
            MSIZE1:  loadValue = memUnsigned ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            MSIZE2:  loadValue = memUnsigned ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            MSIZE4:  loadValue = memUnsigned ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: loadValue = raw;
        endcase
    end

endmodule

// File: rtl/memory.sv
// Memory pipeline stage: issues data-bus transactions, stalls while one is outstanding, registers the result.
module memory
    import memory_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          validE,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output logic          stallM,
    output memory_data_t  dataM,
    output logic          validM,
    output forward_data_t forward,
    output mem_state_t    debugState
);

    mem_state_t       state;
    mem_state_t       stateNext;
    logic             memop;
    logic             misalign;
    logic             dreqValid;
    strobe_t          strobe;
    word_t            busData;
    logic [XLEN-1:0]  loadValue;
    memory_data_t     dataNext;
    logic             unusedAddrOk;

    // Completion is defined by data_ok alone.
    assign unusedAddrOk = dresp.addr_ok;

    memory_format #(.MISALIGN_CHECK(MISALIGN_CHECK)) format (
        .offset     (dataE.result_alu[2:0]),
        .msize      (dataE.ctl.msize),
        .memread    (dataE.ctl.memread),
        .memwrite   (dataE.ctl.memwrite),
        .memUnsigned(dataE.ctl.mem_unsigned),
        .storeData  (dataE.wd),
        .readData   (dresp.data),
        .strobe     (strobe),
        .busData    (busData),
        .loadValue  (loadValue),
        .misalign   (misalign)
    );

    assign memop = validE && (dataE.ctl.memread || dataE.ctl.memwrite) && !misalign;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (memop && !dresp.data_ok) stateNext = BUSY;
            BUSY:    if (dresp.data_ok)           stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Request fields come straight from dataE, which stallM holds steady while BUSY.
    always_comb begin
        dreqValid = 1'b0;
        stallM    = 1'b0;
        unique case (state)
            IDLE: begin
                dreqValid = memop;
                stallM    = memop && !dresp.data_ok;
            end
            BUSY: begin
                dreqValid = 1'b1;
                stallM    = !dresp.data_ok;
            end
            default: ;
        endcase
    end

    assign dreq.valid  = dreqValid;
    assign dreq.addr   = dataE.result_alu;
    assign dreq.size   = dataE.ctl.msize;
    assign dreq.strobe = strobe;
    assign dreq.data   = busData;
    assign debugState  = state;

    always_comb begin
        dataNext              = '0;
        dataNext.pc           = dataE.pc;
        dataNext.ctl          = dataE.ctl;
        dataNext.ctl.regwrite = dataE.ctl.regwrite && !misalign;
        dataNext.result       = (dataE.ctl.memread && !misalign) ? loadValue : dataE.result_alu;
        dataNext.wa           = dataE.wa;
        dataNext.misalign     = misalign;
    end

    // A stall cycle turns into a bubble; only regwrite must be cleared for it to be harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            validM <= 1'b0;
            dataM  <= '0;
        end else if (!stallM) begin
            validM <= validE;
            dataM  <= dataNext;
        end else begin
            validM             <= 1'b0;
            dataM.ctl.regwrite <= 1'b0;
        end
    end

    assign forward.regwriteM = validM && dataM.ctl.regwrite;
    assign forward.waM       = dataM.wa;
    assign forward.resultM   = dataM.result;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the memory stage: directed scenarios plus randomized ops against a byte-level model.
module tb_memory;
    import memory_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    logic          validE;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    logic          stallM;
    memory_data_t  dataM;
    logic          validM;
    forward_data_t forward;
    mem_state_t    debugState;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory #(.XLEN(64), .MISALIGN_CHECK(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .dataE     (dataE),
        .validE    (validE),
        .dreq      (dreq),
        .dresp     (dresp),
        .stallM    (stallM),
        .dataM     (dataM),
        .validM    (validM),
        .forward   (forward),
        .debugState(debugState)
    );

    // ---------------- reference model ----------------
    function automatic int sizeBytes(input msize_t s);
        return 1 << int'(s);
    endfunction

    function automatic logic modelMisalign(input logic [63:0] addr, input msize_t s);
        return (addr % 64'(sizeBytes(s))) != 0;
    endfunction

    function automatic logic [7:0] modelStrobe(input logic [63:0] addr, input msize_t s);
        logic [7:0] r;
        int off;
        off = int'(addr[2:0]);
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = (i >= off) && (i < off + sizeBytes(s));
        return r;
    endfunction

    function automatic logic [63:0] modelWdata(input logic [63:0] addr, input logic [63:0] wd);
        logic [63:0] r;
        int off;
        off = int'(addr[2:0]);
        r = '0;
        for (int j = 0; j < 8; j++) if (j >= off) r[8*j +: 8] = wd[8*(j-off) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] modelLoad(input logic [63:0] addr, input msize_t s,
                                              input logic uns, input logic [63:0] rdata);
        logic [63:0] v;
        logic [63:0] one;
        logic [63:0] mask;
        int off;
        int n;
        off = int'(addr[2:0]);
        n = sizeBytes(s);
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = rdata[8*(off+k) +: 8];
        one = 64'd1;
        mask = (n == 8) ? '1 : ((one << (8*n)) - 1);
        if (!uns && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveOp(input logic rw, input logic rd, input logic wr, input msize_t sz,
                           input logic uns, input logic [63:0] alu, input logic [63:0] wd,
                           input logic [4:0] wa);
        dataE.pc               = 64'h8000_0000 + 64'($urandom_range(0, 1023) * 4);
        dataE.ctl.regwrite     = rw;
        dataE.ctl.memread      = rd;
        dataE.ctl.memwrite     = wr;
        dataE.ctl.msize        = sz;
        dataE.ctl.mem_unsigned = uns;
        dataE.result_alu       = alu;
        dataE.wd               = wd;
        dataE.wa               = wa;
        validE                 = 1'b1;
    endtask

    task automatic idleInputs();
        validE        = 1'b0;
        dataE         = '0;
        dresp.addr_ok = 1'b0;
        dresp.data_ok = 1'b0;
        dresp.data    = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        idleInputs();
        step();
        step();
        checks++; if (validM !== 1'b0) begin errors++; $display("FAIL reset_validM: got %b expected 0", validM); end
        checks++; if (dataM !== memory_data_t'(0)) begin errors++; $display("FAIL reset_dataM: got %h expected 0", dataM); end
        checks++; if (dreq.valid !== 1'b0) begin errors++; $display("FAIL reset_dreq_valid: got %b expected 0", dreq.valid); end
        checks++; if (forward.regwriteM !== 1'b0) begin errors++; $display("FAIL reset_regwriteM: got %b expected 0", forward.regwriteM); end
        checks++; if (debugState !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", debugState); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_alu();
        driveOp(1'b1, 1'b0, 1'b0, MSIZE8, 1'b0, 64'h1234, 64'h0, 5'd7);
        #1;
        checks++; if (dreq.valid !== 1'b0) begin errors++; $display("FAIL alu_dreq_valid: got %b expected 0", dreq.valid); end
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b expected 0", stallM); end
        step();
        validE = 1'b0;
        checks++; if (validM !== 1'b1) begin errors++; $display("FAIL alu_validM: got %b expected 1", validM); end
        checks++; if (dataM.result !== 64'h1234) begin errors++; $display("FAIL alu_result: got %h expected 1234", dataM.result); end
        checks++; if (forward.regwriteM !== 1'b1) begin errors++; $display("FAIL alu_regwriteM: got %b expected 1", forward.regwriteM); end
        checks++; if (forward.waM !== 5'd7) begin errors++; $display("FAIL alu_waM: got %0d expected 7", forward.waM); end
        #1;
        checks++; if (dreq.valid !== 1'b0) begin errors++; $display("FAIL alu_dreq_after: got %b expected 0", dreq.valid); end
    endtask

    task automatic test_store_wait();
        driveOp(1'b0, 1'b0, 1'b1, MSIZE1, 1'b0, 64'h8000_0003, 64'hAB, 5'd0);
        dresp.data_ok = 1'b0;
        #1;
        checks++; if (dreq.valid !== 1'b1) begin errors++; $display("FAIL sb_dreq_valid: got %b expected 1", dreq.valid); end
        checks++; if (dreq.strobe !== 8'h08) begin errors++; $display("FAIL sb_strobe: got %h expected 08", dreq.strobe); end
        checks++; if (dreq.data[31:24] !== 8'hAB) begin errors++; $display("FAIL sb_data: got %h expected ab", dreq.data[31:24]); end
        checks++; if (dreq.addr !== 64'h8000_0003) begin errors++; $display("FAIL sb_addr: got %h expected 80000003", dreq.addr); end
        checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL sb_stall0: got %b expected 1", stallM); end
        step();
        checks++; if (debugState !== BUSY) begin errors++; $display("FAIL sb_state_busy: got %0d expected BUSY", debugState); end
        checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL sb_stall1: got %b expected 1", stallM); end
        checks++; if (dreq.strobe !== 8'h08) begin errors++; $display("FAIL sb_strobe_held: got %h expected 08", dreq.strobe); end
        checks++; if (validM !== 1'b0) begin errors++; $display("FAIL sb_bubble: got %b expected 0", validM); end
        step();
        dresp.data_ok = 1'b1;
        #1;
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL sb_stall_done: got %b expected 0", stallM); end
        checks++; if (dreq.valid !== 1'b1) begin errors++; $display("FAIL sb_dreq_busy: got %b expected 1", dreq.valid); end
        step();
        validE = 1'b0;
        dresp.data_ok = 1'b0;
        checks++; if (validM !== 1'b1) begin errors++; $display("FAIL sb_validM: got %b expected 1", validM); end
        checks++; if (debugState !== IDLE) begin errors++; $display("FAIL sb_state_idle: got %0d expected IDLE", debugState); end
    endtask

    task automatic test_load_extend();
        logic [63:0] rdata [4];
        logic [63:0] addrs [4];
        msize_t      sizes [4];
        logic        unsv  [4];
        logic [63:0] expv  [4];
        rdata[0] = 64'h0000_80FF_0000_0000; addrs[0] = 64'h1005; sizes[0] = MSIZE1; unsv[0] = 1'b0; expv[0] = 64'hFFFF_FFFF_FFFF_FF80;
        rdata[1] = 64'h0000_80FF_0000_0000; addrs[1] = 64'h1005; sizes[1] = MSIZE1; unsv[1] = 1'b1; expv[1] = 64'h80;
        rdata[2] = {32'h8765_4321, $urandom}; addrs[2] = 64'h1004; sizes[2] = MSIZE4; unsv[2] = 1'b0; expv[2] = 64'hFFFF_FFFF_8765_4321;
        rdata[3] = {32'h8765_4321, $urandom}; addrs[3] = 64'h1004; sizes[3] = MSIZE4; unsv[3] = 1'b1; expv[3] = 64'h8765_4321;
        for (int i = 0; i < 4; i++) begin
            driveOp(1'b1, 1'b1, 1'b0, sizes[i], unsv[i], addrs[i], 64'h0, 5'd9);
            dresp.data_ok = 1'b1;
            dresp.data    = rdata[i];
            #1;
            checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL load%0d_stall: got %b expected 0", i, stallM); end
            checks++; if (dreq.strobe !== 8'h00) begin errors++; $display("FAIL load%0d_strobe: got %h expected 00", i, dreq.strobe); end
            step();
            checks++; if (dataM.result !== expv[i]) begin errors++; $display("FAIL load%0d_result: got %h expected %h", i, dataM.result, expv[i]); end
        end
        idleInputs();
        step();
    endtask

    task automatic test_misalign();
        driveOp(1'b1, 1'b0, 1'b1, MSIZE8, 1'b0, 64'h1004, 64'h1122_3344_5566_7788, 5'd3);
        dresp.data_ok = 1'b0;
        #1;
        checks++; if (dreq.valid !== 1'b0) begin errors++; $display("FAIL mis_dreq_valid: got %b expected 0", dreq.valid); end
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b expected 0", stallM); end
        step();
        validE = 1'b0;
        checks++; if (validM !== 1'b1) begin errors++; $display("FAIL mis_validM: got %b expected 1", validM); end
        checks++; if (dataM.misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", dataM.misalign); end
        checks++; if (dataM.ctl.regwrite !== 1'b0) begin errors++; $display("FAIL mis_regwrite: got %b expected 0", dataM.ctl.regwrite); end
        checks++; if (forward.regwriteM !== 1'b0) begin errors++; $display("FAIL mis_regwriteM: got %b expected 0", forward.regwriteM); end
    endtask

    task automatic test_reset_busy();
        logic [63:0] rdata;
        driveOp(1'b1, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h2000, 64'h0, 5'd4);
        dresp.data_ok = 1'b0;
        #1;
        checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL rb_stall: got %b expected 1", stallM); end
        step();
        checks++; if (debugState !== BUSY) begin errors++; $display("FAIL rb_busy: got %0d expected BUSY", debugState); end
        reset  = 1'b1;
        validE = 1'b0;
        step();
        reset = 1'b0;
        #1;
        checks++; if (dreq.valid !== 1'b0) begin errors++; $display("FAIL rb_dreq_valid: got %b expected 0", dreq.valid); end
        checks++; if (validM !== 1'b0) begin errors++; $display("FAIL rb_validM: got %b expected 0", validM); end
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL rb_stallM: got %b expected 0", stallM); end
        checks++; if (debugState !== IDLE) begin errors++; $display("FAIL rb_state: got %0d expected IDLE", debugState); end
        rdata = {$urandom, $urandom};
        driveOp(1'b1, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h2008, 64'h0, 5'd5);
        dresp.data_ok = 1'b0;
        step();
        dresp.data_ok = 1'b1;
        dresp.data    = rdata;
        #1;
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL rb_ld_stall: got %b expected 0", stallM); end
        step();
        checks++; if (validM !== 1'b1 || dataM.result !== rdata) begin
            errors++; $display("FAIL rb_ld_result: got v=%b %h expected v=1 %h", validM, dataM.result, rdata);
        end
        idleInputs();
        step();
    endtask

    task automatic test_random();
        int          kind;
        int          waitc;
        msize_t      sz;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] rdata;
        logic [63:0] expResult;
        logic [4:0]  wa;
        logic        rw;
        logic        uns;
        logic        mis;
        logic        issue;
        for (int i = 0; i < 80; i++) begin
            kind  = $urandom_range(0, 2);
            sz    = msize_t'($urandom_range(0, 3));
            addr  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr = addr & ~(64'(sizeBytes(sz)) - 64'd1);
            wd    = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            wa    = 5'($urandom_range(0, 31));
            rw    = (kind != 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            uns   = 1'($urandom_range(0, 1));
            mis   = (kind != 0) && modelMisalign(addr, sz);
            issue = (kind != 0) && !mis;
            waitc = issue ? $urandom_range(0, 3) : 0;
            expResult = (kind == 1 && !mis) ? modelLoad(addr, sz, uns, rdata) : addr;
            driveOp(rw, kind == 1, kind == 2, sz, uns, addr, wd, wa);
            dresp.data_ok = (waitc == 0);
            dresp.data    = (waitc == 0) ? rdata : {$urandom, $urandom};
            #1;
            checks++; if (dreq.valid !== issue) begin errors++; $display("FAIL rnd%0d_dreq_valid: got %b expected %b", i, dreq.valid, issue); end
            if (issue) begin
                checks++; if (dreq.addr !== addr || dreq.size !== sz) begin
                    errors++; $display("FAIL rnd%0d_addr_size: got %h/%0d expected %h/%0d", i, dreq.addr, dreq.size, addr, sz);
                end
                checks++; if (dreq.strobe !== ((kind == 2) ? modelStrobe(addr, sz) : 8'h00)) begin
                    errors++; $display("FAIL rnd%0d_strobe: got %h expected %h", i, dreq.strobe, (kind == 2) ? modelStrobe(addr, sz) : 8'h00);
                end
                if (kind == 2) begin
                    checks++; if (dreq.data !== modelWdata(addr, wd)) begin
                        errors++; $display("FAIL rnd%0d_wdata: got %h expected %h", i, dreq.data, modelWdata(addr, wd));
                    end
                end
            end
            for (int w = 0; w < waitc; w++) begin
                checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL rnd%0d_wait%0d_stall: got %b expected 1", i, w, stallM); end
                step();
                checks++; if (validM !== 1'b0 || dreq.valid !== 1'b1) begin
                    errors++; $display("FAIL rnd%0d_wait%0d_bubble: got validM=%b dreq=%b expected 0/1", i, w, validM, dreq.valid);
                end
                dresp.data_ok = (w == waitc - 1);
                dresp.data    = (w == waitc - 1) ? rdata : {$urandom, $urandom};
                #1;
            end
            checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL rnd%0d_stall_end: got %b expected 0", i, stallM); end
            step();
            checks++; if (validM !== 1'b1 || dataM.misalign !== mis || dataM.wa !== wa) begin
                errors++; $display("FAIL rnd%0d_meta: got v=%b mis=%b wa=%0d expected 1/%b/%0d", i, validM, dataM.misalign, dataM.wa, mis, wa);
            end
            checks++; if (forward.regwriteM !== (rw && !mis)) begin
                errors++; $display("FAIL rnd%0d_regwriteM: got %b expected %b", i, forward.regwriteM, rw && !mis);
            end
            if (!mis) begin
                checks++; if (forward.resultM !== expResult) begin
                    errors++; $display("FAIL rnd%0d_result: got %h expected %h", i, forward.resultM, expResult);
                end
            end
        end
        idleInputs();
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_wait();
        test_load_extend();
        test_misalign();
        test_reset_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
